// File: rtl/conv_mac_scheduler.sv
// rtl/conv_mac_scheduler.sv - address/control sequencer for one valid-mode 2D convolution pass
module conv_mac_scheduler #(
  parameter int X  = 5,
  parameter int H  = 3,
  parameter int AW = 14,
  parameter int HW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] addr_x,
  output logic [HW-1:0] addr_h,
  output logic          acc_first,
  output logic          acc_en,
  output logic          wr_en_y,
  output logic [AW-1:0] addr_y
);

  localparam int O = X - H + 1;
  localparam logic [AW-1:0] XA  = AW'(X);
  localparam logic [AW-1:0] OA  = AW'(O);
  localparam logic [AW-1:0] HM  = AW'(H - 1);
  localparam logic [AW-1:0] OM  = AW'(O - 1);
  localparam logic [AW-1:0] ONE = AW'(1);
  localparam logic [HW-1:0] HH  = HW'(H);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [AW-1:0] r_orow, r_ocol, r_ki, r_kj;
  logic          r_drain;
  logic          r_s1_valid, r_s1_first, r_s1_last;
  logic [AW-1:0] r_s1_win;
  logic          r_s2_valid;
  logic [AW-1:0] r_addr_y;

  logic w_issue, w_kj_end, w_ki_end, w_ocol_end, w_orow_end, w_last_tap;

  assign w_issue    = (r_state == S_RUN) && !stall;
  assign w_kj_end   = (r_kj == HM);
  assign w_ki_end   = (r_ki == HM);
  assign w_ocol_end = (r_ocol == OM);
  assign w_orow_end = (r_orow == OM);
  assign w_last_tap = w_kj_end && w_ki_end && w_ocol_end && w_orow_end;

  // Issue-stage addresses come straight from the counters, so they hold while stalled.
  assign addr_x = (r_orow + r_ki) * XA + r_ocol + r_kj;
  assign addr_h = HW'(r_ki) * HH + HW'(r_kj);
  assign addr_y = r_addr_y;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and output decode; stall masks the strobes of frozen pipeline stages.
  always_comb begin
    w_next    = r_state;
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    acc_en    = r_s1_valid && !stall;
    acc_first = r_s1_valid && r_s1_first && !stall;
    wr_en_y   = r_s2_valid && !stall;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_issue && w_last_tap) w_next = S_DRAIN;
      S_DRAIN: if (!stall && r_drain) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Two-cycle drain timer covering pipeline stages 1 and 2 after the last issue.
  always_ff @(posedge clk) begin
    if (reset) r_drain <= 1'b0;
    else if (r_state == S_DRAIN && !stall) r_drain <= ~r_drain;
  end

  // Window/tap walk: kj fastest, then ki, ocol, orow; wraps to zero after the last tap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_orow <= '0;
      r_ocol <= '0;
      r_ki   <= '0;
      r_kj   <= '0;
    end else if (w_issue) begin
      if (w_kj_end) begin
        r_kj <= '0;
        if (w_ki_end) begin
          r_ki <= '0;
          if (w_ocol_end) begin
            r_ocol <= '0;
            r_orow <= w_orow_end ? '0 : r_orow + ONE;
          end else begin
            r_ocol <= r_ocol + ONE;
          end
        end else begin
          r_ki <= r_ki + ONE;
        end
      end else begin
        r_kj <= r_kj + ONE;
      end
    end
  end

  // Stage 1 tracks the tap whose read data is arriving; stage 2 carries the window write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_win   <= '0;
      r_s2_valid <= 1'b0;
      r_addr_y   <= '0;
    end else if (!stall) begin
      r_s1_valid <= (r_state == S_RUN);
      r_s1_first <= (r_ki == '0) && (r_kj == '0);
      r_s1_last  <= w_kj_end && w_ki_end;
      r_s1_win   <= r_orow * OA + r_ocol;
      r_s2_valid <= r_s1_valid && r_s1_last;
      if (r_s1_valid && r_s1_last) r_addr_y <= r_s1_win;
    end
  end

endmodule
